// File: rtl/survivor_ring_if.sv
// Bundle of write-handshake, read-request and status signals of the survivor-path store.
// The master drives rows and read requests; the slave is the store itself.
interface survivor_ring_if #(
  parameter int unsigned S  = 16,
  parameter int unsigned B  = 1,
  parameter int unsigned M  = 4,
  parameter int unsigned AW = 4,
  parameter int unsigned FW = 4
);
  logic           frame_start;
  logic           wr_valid;
  logic           wr_ready;
  logic [S*B-1:0] wr_row;
  logic           rd_en;
  logic [AW-1:0]  rd_age;
  logic [M-1:0]   rd_state;
  logic           rd_valid;
  logic [B-1:0]   rd_bits;
  logic           rd_err;
  logic [FW-1:0]  fill;
  logic           full;
  logic [AW-1:0]  wr_ptr;

  modport master (
    output frame_start, wr_valid, wr_row, rd_en, rd_age, rd_state,
    input  wr_ready, rd_valid, rd_bits, rd_err, fill, full, wr_ptr
  );

  modport slave (
    input  frame_start, wr_valid, wr_row, rd_en, rd_age, rd_state,
    output wr_ready, rd_valid, rd_bits, rd_err, fill, full, wr_ptr
  );
endinterface

// File: rtl/survivor_ring.sv
// Survivor-path ring store: one decision row per trellis step, read back by age
// relative to the newest row, with a registered 1-cycle read path.
module survivor_ring #(
  parameter int unsigned K         = 5,
  parameter int unsigned M         = K - 1,
  parameter int unsigned S         = 1 << M,
  parameter int unsigned B         = 1,
  parameter int unsigned D         = 10,
  parameter int unsigned OVERWRITE = 1,
  parameter int unsigned AW        = $clog2(D),
  parameter int unsigned FW        = $clog2(D + 1)
) (
  input logic            clk,
  input logic            rst_n,
  survivor_ring_if.slave bus
);

  logic [S*B-1:0] mem_q [D];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [AW-1:0]  rd_idx;
  logic           full;
  logic           accept;
  logic           rd_oor;
  logic           rd_valid_q;
  logic           rd_err_q, rd_err_d;
  logic [B-1:0]   rd_bits_q, rd_bits_d;

  assign full          = (fill_q == FW'(D));
  assign bus.wr_ready  = rst_n && ((OVERWRITE != 0) || !full);
  // frame_start wins over a simultaneous write: the offered row is dropped.
  assign accept        = bus.wr_valid && bus.wr_ready && !bus.frame_start;

  assign bus.fill      = fill_q;
  assign bus.full      = full;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_bits   = rd_bits_q;
  assign bus.rd_err    = rd_err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (bus.frame_start) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (accept) begin
      wr_ptr_d = (wr_ptr_q == AW'(D - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (!full) fill_d = fill_q + FW'(1);
    end
  end

  // Modular index without assuming D is a power of two; AW-bit wraparound is harmless
  // because the in-range result always lies in [0, D-1].
  always_comb begin
    if (wr_ptr_q > bus.rd_age) begin
      rd_idx = wr_ptr_q - bus.rd_age - AW'(1);
    end else begin
      rd_idx = wr_ptr_q - bus.rd_age - AW'(1) + AW'(D);
    end
    rd_oor    = (32'(bus.rd_age) >= 32'(fill_q)) || (32'(bus.rd_age) >= D);
    rd_bits_d = '0;
    rd_err_d  = 1'b1;
    if (!rd_oor) begin
      rd_bits_d = mem_q[rd_idx][bus.rd_state*B +: B];
      rd_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_bits_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_bits_q <= rd_bits_d;
        rd_err_q  <= rd_err_d;
      end
    end
  end

  // Storage is never cleared; fill masks stale rows.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.wr_row;
  end

endmodule
